// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Each trial subtraction is a WIDTH+1-bit ripple chain of inverted-operand full-adder cells.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_trial;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  logic             no_borrow;

  // a - b as a + ~b + 1 through a chain of full-adder cells; MSB of the result is the carry-out.
  function automatic logic [WIDTH+1:0] sub_chain(input logic [WIDTH:0] a,
                                                 input logic [WIDTH:0] b);
    logic           c;
    logic [WIDTH:0] d;
    c = 1'b1;
    d = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      d[i] = a[i] ^ ~b[i] ^ c;
      c    = (a[i] & ~b[i]) | ((a[i] ^ ~b[i]) & c);
    end
    return {c, d};
  endfunction

  always_comb begin
    p_shift              = {p[WIDTH-1:0], q[WIDTH-1]};
    {no_borrow, p_trial} = sub_chain(p_shift, {1'b0, dvsr});
    p_next               = no_borrow ? p_trial : p_shift;
    q_next               = {q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge C) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start && (divisor != '0)) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (count == CW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      p           <= '0;
      q           <= '0;
      dvsr        <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Divide-by-zero resolves immediately without entering RUN.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              p           <= '0;
              q           <= dividend;
              dvsr        <= divisor;
              count       <= CW'(WIDTH);
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          p     <= p_next;
          q     <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient  <= q_next;
            remainder <= p_next[WIDTH-1:0];
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=8 and WIDTH=16 against a cycle-level arithmetic model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst8, start8, busy8, done8, dz8;
  logic [7:0]  a8, b8, quotient8, remainder8;
  logic        rst16, start16, busy16, done16, dz16;
  logic [15:0] a16, b16, quotient16, remainder16;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut8 (
    .C(clk), .R(rst8), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dz8));

  seq_divider #(.WIDTH(16)) dut16 (
    .C(clk), .R(rst16), .start(start16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16),
    .div_by_zero(dz16));

  typedef struct {
    int          rem;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] pq;
    logic [31:0] pr;
  } model_t;

  model_t m8, m16;

  // Operation-level model: an accepted divide finishes w edges later with a/b and a%b.
  function automatic model_t step(input model_t m, input logic rst, input logic st,
                                  input logic [31:0] a, input logic [31:0] b, input int w);
    model_t n;
    n = m;
    if (rst) begin
      n.rem = 0; n.busy = 0; n.done = 0; n.dz = 0; n.q = 0; n.r = 0;
      return n;
    end
    n.done = 1'b0;
    if (m.rem == 0) begin
      if (st) begin
        if (b == 0) begin
          n.q = (32'h1 << w) - 32'h1;
          n.r = a; n.dz = 1'b1; n.done = 1'b1;
        end else begin
          n.rem = w; n.pq = a / b; n.pr = a % b; n.dz = 1'b0;
        end
      end
    end else begin
      n.rem = m.rem - 1;
      if (n.rem == 0) begin
        n.done = 1'b1; n.q = m.pq; n.r = m.pr;
      end
    end
    n.busy = (n.rem != 0);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    m8  = '{rem: 0, busy: 0, done: 0, dz: 0, q: 0, r: 0, pq: 0, pr: 0};
    m16 = m8;
  end

  always @(posedge clk) begin
    m8  = step(m8,  rst8,  start8,  {24'd0, a8},  {24'd0, b8},  8);
    m16 = step(m16, rst16, start16, {16'd0, a16}, {16'd0, b16}, 16);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("w8 busy",       {31'd0, busy8}, {31'd0, m8.busy});
      chk("w8 done",       {31'd0, done8}, {31'd0, m8.done});
      chk("w8 dz",         {31'd0, dz8},   {31'd0, m8.dz});
      chk("w8 quotient",   {24'd0, quotient8},  m8.q);
      chk("w8 remainder",  {24'd0, remainder8}, m8.r);
      chk("w8 busy&done",  {31'd0, busy8 & done8}, 32'd0);
      chk("w16 busy",      {31'd0, busy16}, {31'd0, m16.busy});
      chk("w16 done",      {31'd0, done16}, {31'd0, m16.done});
      chk("w16 dz",        {31'd0, dz16},   {31'd0, m16.dz});
      chk("w16 quotient",  {16'd0, quotient16},  m16.q);
      chk("w16 remainder", {16'd0, remainder16}, m16.r);
      chk("w16 busy&done", {31'd0, busy16 & done16}, 32'd0);
    end
  end

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [7:0] eq,
                           input logic [7:0] er, input logic edz);
    int n;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done_seen"}, {31'd0, done8}, 32'd1);
    chk({nm, " latency"}, n, lat);
    chk({nm, " quotient"},  {24'd0, quotient8},  {24'd0, eq});
    chk({nm, " remainder"}, {24'd0, remainder8}, {24'd0, er});
    chk({nm, " dz"}, {31'd0, dz8}, {31'd0, edz});
    chk({nm, " model_q"}, m8.q, {24'd0, eq});
    chk({nm, " model_r"}, m8.r, {24'd0, er});
  endtask

  initial begin
    logic saw;
    rst8 = 1'b1; rst16 = 1'b1; start8 = 0; start16 = 0;
    a8 = 0; b8 = 0; a16 = 0; b16 = 0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    cmp_en = 1'b1;
    chk("reset busy", {31'd0, busy8}, 32'd0);
    chk("reset quotient", {24'd0, quotient8}, 32'd0);
    chk("reset remainder", {24'd0, remainder8}, 32'd0);

    fork
      begin
        start_op(8'd100, 8'd7);
        wait_done("100/7", 8, 8'd14, 8'd2, 1'b0);
        @(negedge clk);
        start_op(8'd255, 8'd1);
        wait_done("255/1", 8, 8'd255, 8'd0, 1'b0);
        start_op(8'd5, 8'd9);
        wait_done("5/9 b2b", 8, 8'd0, 8'd5, 1'b0);
        @(negedge clk);
        start_op(8'd37, 8'd0);
        chk("37/0 busy", {31'd0, busy8}, 32'd0);
        wait_done("37/0", 0, 8'hFF, 8'd37, 1'b1);
        @(negedge clk);
        start_op(8'd200, 8'd10);
        wait_done("200/10", 8, 8'd20, 8'd0, 1'b0);
        @(negedge clk);
        start_op(8'd200, 8'd3);
        repeat (2) @(negedge clk);
        start_op(8'd50, 8'd5);
        wait_done("200/3 ignore", 5, 8'd66, 8'd2, 1'b0);
        @(negedge clk);
        start_op(8'd250, 8'd4);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("midrst busy", {31'd0, busy8}, 32'd0);
        chk("midrst done", {31'd0, done8}, 32'd0);
        chk("midrst quotient", {24'd0, quotient8}, 32'd0);
        chk("midrst remainder", {24'd0, remainder8}, 32'd0);
        saw = 1'b0;
        repeat (12) begin
          @(negedge clk);
          saw = saw | done8;
        end
        chk("midrst no_done", {31'd0, saw}, 32'd0);
        start_op(8'd9, 8'd2);
        wait_done("9/2", 8, 8'd4, 8'd1, 1'b0);
        for (int i = 0; i < 30000; i++) begin
          @(negedge clk);
          rst8   = ($urandom_range(0, 1999) == 0);
          start8 = 1'($urandom_range(0, 1));
          a8     = 8'($urandom);
          b8     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        end
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
      end
      begin
        for (int j = 0; j < 40000; j++) begin
          @(negedge clk);
          rst16   = ($urandom_range(0, 2999) == 0);
          start16 = 1'($urandom_range(0, 1));
          a16     = 16'($urandom);
          case ($urandom_range(0, 7))
            0:       b16 = 16'd0;
            1:       b16 = 16'($urandom_range(1, 15));
            default: b16 = 16'($urandom);
          endcase
        end
        @(negedge clk);
        rst16 = 1'b0; start16 = 1'b0;
      end
    join

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
